// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : puf_pkg
//  Description : Shared types, default widths and timing helpers for the
//                ring-oscillator PUF challenge controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package puf_pkg;

    localparam int PUF_CHAL_W    = 5;
    localparam int PUF_CNT_W     = 8;
    localparam int PUF_RESP_BITS = 8;
    localparam int PUF_WINDOW    = 256;
    localparam int PUF_SETTLE    = 4;

    localparam int PUF_ST_W = 3;

    typedef enum logic [PUF_ST_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_FREEZE = 3'd3,
        ST_EVAL   = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_e;

    // Cycles spent on one response bit: clear + window + freeze + evaluate
    function automatic int puf_bit_cycles(input int window, input int settle);
        return 2 * settle + window + 1;
    endfunction

    function automatic int puf_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/puf_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : puf_phase_timer
//  Description : Loadable down-counter that flags when it has reached zero.
//                Loading N keeps the owning phase alive for N+1 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_phase_timer #(
    parameter int TMR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Load takes priority; otherwise count down and rest at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : puf_challenge_ctrl
//  Description : Issues a run of challenges to a ring-oscillator PUF pair,
//                gates the oscillators for a fixed window per challenge,
//                compares the frozen edge counts into response bits and
//                hands the response word out over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module puf_challenge_ctrl
    import puf_pkg::*;
#(
    parameter int CHAL_W    = PUF_CHAL_W,
    parameter int CNT_W     = PUF_CNT_W,
    parameter int RESP_BITS = PUF_RESP_BITS,
    parameter int WINDOW    = PUF_WINDOW,
    parameter int SETTLE    = PUF_SETTLE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAL_W-1:0]    chal_seed,
    output logic                 busy,
    output logic                 ro_ena,
    output logic [CHAL_W-1:0]    chal_out,
    output logic                 cnt_clr,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie_flag,
    output logic                 sat_flag
);

    localparam int TMR_W = $clog2(puf_max(WINDOW, SETTLE)) + 1;
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [TMR_W-1:0] c_settle_load = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] c_window_load = TMR_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] c_last_idx    = IDX_W'(RESP_BITS - 1);
    localparam logic [CNT_W-1:0] c_cnt_max     = '1;

    // Note: the port named rst_n is an active-high synchronous reset.

    puf_state_e state_q, state_d;

    logic [CHAL_W-1:0]    chal_q, chal_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 tie_q, tie_d;
    logic                 sat_q, sat_d;
    logic                 busy_q, busy_d;
    logic                 ro_ena_q, ro_ena_d;
    logic                 cnt_clr_q, cnt_clr_d;
    logic                 resp_valid_q, resp_valid_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             w_last_bit;
    logic             w_handshake;

    assign w_last_bit  = (bit_idx_q == c_last_idx);
    assign w_handshake = resp_valid_q & resp_ready;

    puf_phase_timer #(
        .TMR_W (TMR_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the phase timer is loaded on entry to each timed phase
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = c_settle_load;
                end
            end
            ST_CLEAR: begin
                if (tmr_done) begin
                    state_d  = ST_RUN;
                    tmr_load = 1'b1;
                    tmr_val  = c_window_load;
                end
            end
            ST_RUN: begin
                if (tmr_done) begin
                    state_d  = ST_FREEZE;
                    tmr_load = 1'b1;
                    tmr_val  = c_settle_load;
                end
            end
            ST_FREEZE: begin
                if (tmr_done) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (w_last_bit) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_CLEAR;
                    tmr_load = 1'b1;
                    tmr_val  = c_settle_load;
                end
            end
            ST_DONE: begin
                if (w_handshake) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; strobes follow the state one cycle
    // later so they leave registers and can never both be high
    always_comb begin
        chal_d       = chal_q;
        bit_idx_d    = bit_idx_q;
        resp_d       = resp_q;
        tie_d        = tie_q;
        sat_d        = sat_q;
        busy_d       = (state_d != ST_IDLE);
        cnt_clr_d    = (state_q == ST_CLEAR);
        ro_ena_d     = (state_q == ST_RUN);
        resp_valid_d = (state_q == ST_DONE) && !w_handshake;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d    = chal_seed;
                    bit_idx_d = '0;
                    resp_d    = '0;
                    tie_d     = 1'b0;
                    sat_d     = 1'b0;
                end
            end
            ST_EVAL: begin
                resp_d[bit_idx_q] = (cnt_a > cnt_b);
                tie_d  = tie_q | (cnt_a == cnt_b);
                sat_d  = sat_q | (cnt_a == c_cnt_max) | (cnt_b == c_cnt_max);
                chal_d = chal_q + CHAL_W'(1);
                if (!w_last_bit) begin
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            chal_q       <= '0;
            bit_idx_q    <= '0;
            resp_q       <= '0;
            tie_q        <= 1'b0;
            sat_q        <= 1'b0;
            busy_q       <= 1'b0;
            cnt_clr_q    <= 1'b0;
            ro_ena_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            chal_q       <= chal_d;
            bit_idx_q    <= bit_idx_d;
            resp_q       <= resp_d;
            tie_q        <= tie_d;
            sat_q        <= sat_d;
            busy_q       <= busy_d;
            cnt_clr_q    <= cnt_clr_d;
            ro_ena_q     <= ro_ena_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign busy       = busy_q;
    assign ro_ena     = ro_ena_q;
    assign cnt_clr    = cnt_clr_q;
    assign chal_out   = chal_q;
    assign resp       = resp_q;
    assign resp_valid = resp_valid_q;
    assign tie_flag   = tie_q;
    assign sat_flag   = sat_q;

endmodule
`default_nettype wire

// File: doc/puf_challenge_ctrl.md
Name: puf_challenge_ctrl

Overview:
Synchronous initiator for the ring-oscillator PUF pair. It issues a sequence of challenges (oscillator select codes) and gates the oscillators for a fixed measurement window. After each window it reads the two frozen edge counts and turns each comparison into one response bit. The assembled response word is delivered over a valid/ready handshake. The block sits between the host/test logic and the RO banks, counters and comparator.

Parameters:
CHAL_W, 5, challenge (mux select) width
CNT_W, 8, width of each oscillator edge count
RESP_BITS, 8, response bits per request (1..2**CHAL_W)
WINDOW, 256, clk cycles oscillators are enabled per bit (>=1)
SETTLE, 4, clk cycles of clear and of post-window freeze (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, ACTIVE-HIGH (1 = reset)
start  in  1  request pulse; accepted only in IDLE
chal_seed  in  CHAL_W  first challenge, latched on accept
busy  out  1  high from cycle after accept until handshake completes
ro_ena  out  1  enable to both oscillator banks
chal_out  out  CHAL_W  current challenge to both bank selects
cnt_clr  out  1  clear to both edge counters
cnt_a  in  CNT_W  frozen count, bank A
cnt_b  in  CNT_W  frozen count, bank B
resp  out  RESP_BITS  response word, bit i from challenge i
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
tie_flag  out  1  at least one bit had cnt_a == cnt_b
sat_flag  out  1  at least one count read as all-ones

Behaviour:
- Reset (rst_n=1 at a clk edge): state IDLE. busy, ro_ena, cnt_clr, resp_valid, tie_flag, sat_flag = 0; resp = 0; chal_out = 0. Reset mid-operation aborts at once, and ro_ena drops on the next edge.
- FSM states: IDLE, CLEAR, RUN, FREEZE, EVAL, DONE.
- IDLE: start=1 -> latch chal_seed into chal_out; clear bit_idx, resp, and both flags; go to CLEAR. A start seen in any other state is ignored and never queued.
- CLEAR: cnt_clr=1 and ro_ena=0 for SETTLE cycles, then RUN.
- RUN: ro_ena=1 for exactly WINDOW cycles, then FREEZE.
- FREEZE: ro_ena=0 for SETTLE cycles. Counts are static before EVAL, so no multi-bit synchronizer is needed.
- EVAL (1 cycle):
  - resp[bit_idx] = (cnt_a > cnt_b), unsigned compare; a tie gives 0 and sets tie_flag.
  - Either count equal to all-ones sets sat_flag.
  - chal_out increments modulo 2**CHAL_W, so 31 wraps to 0.
  - If bit_idx == RESP_BITS-1, go to DONE; else increment bit_idx and go to CLEAR.
- DONE: resp_valid=1; resp and both flags held stable. The handshake completes on the edge where resp_ready=1, then IDLE with resp_valid=0 and busy=0. If resp_ready is already high on entry, the handshake completes in the first DONE cycle.
- chal_out is constant throughout CLEAR/RUN/FREEZE for a given bit.
- Latency: per bit = 2*SETTLE + WINDOW + 1 cycles (265 default). resp_valid rises 1 + RESP_BITS*(2*SETTLE+WINDOW+1) cycles after the accepting edge (2121 default).
- ro_ena and cnt_clr are never high together, and both come from registers so they are glitch-free.

Decomposition:
- puf_pkg: state enum, default widths, and a function for per-bit cycle count.
- One sub-module, puf_phase_timer: loadable down-counter, width clog2(max(WINDOW,SETTLE))+1, outputs done when zero. It is reused for CLEAR, RUN and FREEZE durations.

Test Plan:
- Reset, then start=1, chal_seed=5'd3, and a bench model driving cnt_a=200/cnt_b=100 on even bits and 50/90 on odd bits -> resp=8'h55, tie_flag=0, sat_flag=0, resp_valid at cycle 2121 after accept.
- chal_seed=5'd30 -> chal_out observed as 30,31,0,1,2,3,4,5 across the 8 RUN phases (wrap checked). ro_ena high exactly 256 cycles each, and never overlapping cnt_clr.
- Bit 2 counts 77/77 and bit 5 cnt_a=255 -> resp[2]=0, tie_flag=1, sat_flag=1.
- Hold resp_ready=0 for 50 cycles in DONE while toggling start -> resp stable, busy=1, no new run. Pulse resp_ready -> IDLE next cycle; a following start is accepted.
- Assert rst_n during RUN of bit 4 -> next edge ro_ena=0, busy=0, resp=0. A new start runs a full 8-bit sequence.
- Parameter variant WINDOW=1, SETTLE=2, RESP_BITS=1 -> resp_valid 1+(2*2+1+1)=7 cycles after accept.
